ladrao_game_core: RTL and testbench

LADRAO_GAME_CORE -- requirements
Module: ladrao_game_core

---
 rtl/ladrao_pkg.sv | 24 ++
 rtl/ladrao_bcd_countdown.sv | 61 ++++++
 rtl/ladrao_game_core.sv | 120 ++++++++++++
 tb/tb_ladrao_game_core.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ladrao_pkg.sv
// Shared types for the thief-catching game: FSM states, BCD digit, and
// maximal-length Galois LFSR tap masks indexed by register width.
package ladrao_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Tap masks for a right-shifting Galois LFSR (bit n-1 set for tap n).
    localparam logic [31:0] LFSR_TAPS [8:32] = '{
        32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, 32'h0000_0500,
        32'h0000_0829, 32'h0000_100D, 32'h0000_2015, 32'h0000_6000,
        32'h0000_D008, 32'h0001_2000, 32'h0002_0400, 32'h0004_0023,
        32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
        32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013,
        32'h0900_0000, 32'h1400_0000, 32'h2000_0029, 32'h4800_0000,
        32'h8020_0003
    };

endpackage

// File: rtl/ladrao_bcd_countdown.sv
// M:SS BCD countdown: load presets START_MIN:00, each tick subtracts one
// second, and the count parks at 0:00.
module bcd_countdown
    import ladrao_pkg::*;
#(
    parameter int START_MIN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output bcd_t min_bcd,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic zero
);

    bcd_t min_q, min_d, tens_q, tens_d, ones_q, ones_d;

    assign zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        min_d  = min_q;
        tens_d = tens_q;
        ones_d = ones_q;
        if (load) begin
            min_d  = bcd_t'(START_MIN);
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (tick && !zero) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    tens_d = 4'd5;
                    min_d  = min_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q  <= bcd_t'(START_MIN);
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            min_q  <= min_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign min_bcd  = min_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;

endmodule

// File: rtl/ladrao_game_core.sv
// Thief-catching game core: timed round, LFSR-driven thief pattern, score.
// Optional LADRAO_PAUSE_EN adds a pause input that freezes play.
module ladrao_game_core
    import ladrao_pkg::*;
#(
    parameter int          WIDTH     = 18,
    parameter int          TICK_DIV  = 50_000_000,
    parameter int          START_MIN = 3,
    parameter int          MOVE_SEC  = 10,
    parameter logic [31:0] SEED      = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef LADRAO_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] thief,
    output logic             match,
    output logic [3:0]       min_bcd,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic [7:0]       score,
    output logic             game_over,
    output logic [1:0]       state
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] TAPS     = LFSR_TAPS[WIDTH][WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED[WIDTH-1:0] == '0) ? WIDTH'(1) : SEED[WIDTH-1:0];

    state_t           state_q;
    logic [PW-1:0]    presc_q;
    logic [5:0]       move_q;
    logic [WIDTH-1:0] thief_q, lfsr_nxt;
    logic [7:0]       score_q;
    logic             match_q, over_q;
    logic             frozen, run, tick, catch_hit, load, last_sec, zero;

`ifdef LADRAO_PAUSE_EN
    assign frozen = pause;
`else
    assign frozen = 1'b0;
`endif

    assign run       = (state_q == PLAY) && !frozen;
    assign tick      = run && (presc_q == PW'(TICK_DIV - 1));
    assign catch_hit = run && (sw == thief_q);
    assign load      = start && ((state_q == IDLE) || (state_q == OVER));
    assign last_sec  = (min_bcd == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
    assign lfsr_nxt  = (thief_q >> 1) ^ (thief_q[0] ? TAPS : '0);

    bcd_countdown #(.START_MIN(START_MIN)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .tick     (tick),
        .min_bcd  (min_bcd),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            move_q  <= '0;
            thief_q <= SEED_EFF;
            score_q <= '0;
            match_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            match_q <= 1'b0;
            case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q <= PLAY;
                        over_q  <= 1'b0;
                        presc_q <= '0;
                        move_q  <= '0;
                        score_q <= '0;
                    end
                end
                PLAY: begin
                    if (run) begin
                        presc_q <= tick ? '0 : presc_q + PW'(1);
                        // A catch consumes the step, so a coincident move is dropped.
                        if (catch_hit) begin
                            match_q <= 1'b1;
                            thief_q <= lfsr_nxt;
                            move_q  <= '0;
                            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                        end else if (tick) begin
                            if (move_q == 6'(MOVE_SEC - 1)) begin
                                thief_q <= lfsr_nxt;
                                move_q  <= '0;
                            end else begin
                                move_q  <= move_q + 6'd1;
                            end
                        end
                        if (tick && last_sec) begin
                            state_q <= OVER;
                            over_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign thief     = thief_q;
    assign match     = match_q;
    assign score     = score_q;
    assign game_over = over_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ladrao_game_core.sv
// Directed bench for ladrao_game_core (WIDTH=8, TICK_DIV=4, START_MIN=1,
// MOVE_SEC=3); a second instance with a slower tick gives room to saturate the score.
module tb_ladrao_game_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start2 = 1'b0;
    logic [7:0] sw = 8'h00, sw2 = 8'h00;
`ifdef LADRAO_PAUSE_EN
    logic       pause = 1'b0, pause2 = 1'b0;
`endif
    logic [7:0] thief, thief2, score, score2;
    logic       match, match2, game_over, game_over2;
    logic [3:0] min_bcd, sec_tens, sec_ones, min2, tens2, ones2;
    logic [1:0] state, state2;
    logic [11:0] tmr;
    int         errors = 0, checks = 0;
    logic       zero_seen = 1'b0;

    assign tmr = {min_bcd, sec_tens, sec_ones};

    always #5 clk = ~clk;

    ladrao_game_core #(.WIDTH(8), .TICK_DIV(4), .START_MIN(1), .MOVE_SEC(3), .SEED(32'd1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef LADRAO_PAUSE_EN
        .pause(pause),
`endif
        .sw(sw), .thief(thief), .match(match), .min_bcd(min_bcd), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .score(score), .game_over(game_over), .state(state)
    );

    ladrao_game_core #(.WIDTH(8), .TICK_DIV(8), .START_MIN(1), .MOVE_SEC(3), .SEED(32'd1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef LADRAO_PAUSE_EN
        .pause(pause2),
`endif
        .sw(sw2), .thief(thief2), .match(match2), .min_bcd(min2), .sec_tens(tens2),
        .sec_ones(ones2), .score(score2), .game_over(game_over2), .state(state2)
    );

    always @(negedge clk) if (rst_n && (thief === 8'h00 || thief2 === 8'h00)) zero_seen = 1'b1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        step(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_thief", 32'(thief), 32'h01);
        chk("rst_timer", 32'(tmr), 32'h100);
        chk("rst_score", 32'(score), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_over", 32'(game_over), 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_hold", 32'(state), 0);

        // Start and first second
        start = 1'b1; step(1); start = 1'b0;
        chk("start_state", 32'(state), 1);
        chk("start_timer", 32'(tmr), 32'h100);
        step(3);  chk("pre_tick_timer", 32'(tmr), 32'h100);
        step(1);  chk("tick1_timer", 32'(tmr), 32'h059);

        // Thief moves every 12 clocks: 01 -> B8 -> 5C -> 2E
        step(7);  chk("move_not_yet", 32'(thief), 32'h01);
        step(1);  chk("move1", 32'(thief), 32'hB8);
        step(12); chk("move2", 32'(thief), 32'h5C);
        step(12); chk("move3", 32'(thief), 32'h2E);
        chk("timer_051", 32'(tmr), 32'h051);

        // Catch
        sw = 8'h2E; step(1); sw = 8'h00;
        chk("catch_match", 32'(match), 1);
        chk("catch_score", 32'(score), 1);
        chk("catch_thief", 32'(thief), 32'h17);
        step(1);  chk("match_pulse_end", 32'(match), 0);
        step(9);  chk("move_after_catch_wait", 32'(thief), 32'h17);
        step(1);  chk("move_after_catch", 32'(thief), 32'hB3);

        // Run to 0:00
        step(191);
        chk("last_sec_timer", 32'(tmr), 32'h001);
        chk("last_sec_state", 32'(state), 1);
        step(1);
        chk("end_timer", 32'(tmr), 32'h000);
        chk("end_state", 32'(state), 2);
        chk("end_over", 32'(game_over), 1);
        chk("end_score", 32'(score), 1);

        // OVER: no match, timer and score hold
        sw = thief; step(3); sw = 8'h00;
        chk("over_no_match", 32'(match), 0);
        chk("over_timer", 32'(tmr), 32'h000);
        chk("over_score", 32'(score), 1);
        chk("over_state", 32'(state), 2);

        // Score saturation on the slow-tick instance
        start2 = 1'b1; step(1); start2 = 1'b0;
        chk("sat_start_state", 32'(state2), 1);
        for (int i = 0; i < 254; i++) begin sw2 = thief2; step(1); end
        chk("sat_254", 32'(score2), 32'hFE);
        sw2 = thief2; step(1);
        chk("sat_255", 32'(score2), 32'hFF);
        sw2 = thief2; step(1); sw2 = thief2; step(1);
        chk("sat_hold", 32'(score2), 32'hFF);
        chk("sat_match", 32'(match2), 1);
        chk("sat_still_play", 32'(state2), 1);
        sw2 = 8'h00;

        // Restart from OVER, then reset mid-game at 0:37
        start = 1'b1; step(1); start = 1'b0;
        chk("restart_state", 32'(state), 1);
        chk("restart_timer", 32'(tmr), 32'h100);
        chk("restart_score", 32'(score), 0);
        chk("restart_over", 32'(game_over), 0);
        step(92);
        chk("timer_037", 32'(tmr), 32'h037);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_timer", 32'(tmr), 32'h100);
        chk("arst_thief", 32'(thief), 32'h01);
        chk("arst_score", 32'(score), 0);
        chk("arst_match", 32'(match), 0);
        chk("arst_over", 32'(game_over), 0);
        step(2); rst_n = 1'b1;
        step(8);
        chk("post_rst_state", 32'(state), 0);
        chk("post_rst_timer", 32'(tmr), 32'h100);
        chk("post_rst_match", 32'(match), 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("rst_restart_timer", 32'(tmr), 32'h100);
        step(4);
        chk("rst_restart_tick", 32'(tmr), 32'h059);

`ifdef LADRAO_PAUSE_EN
        step(36);
        chk("pause_at_050", 32'(tmr), 32'h050);
        pause = 1'b1; sw = thief;
        step(20);
        chk("pause_timer", 32'(tmr), 32'h050);
        chk("pause_no_match", 32'(match), 0);
        chk("pause_score", 32'(score), 0);
        pause = 1'b0; sw = 8'h00;
`endif

        chk("thief_never_zero", 32'(zero_seen), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
